// File: rtl/decode_alloc_bid_if.sv
// Decode <-> branch-ID allocator signal bundle.
interface decode_alloc_bid_if #(
  parameter int unsigned BID_W = 4
);
  logic             br_req;
  logic             en_alloc;
  logic             snoop_hit;
  logic             bco_valid;
  logic             bc_valid;
  logic [BID_W-1:0] bc_bid;
  logic             bp_valid;
  logic [BID_W-1:0] bp_bid;
  logic             readyn;
  logic [2:0]       inflight_cnt;
  logic             err_order;
  logic             err_underflow;

  // Decode / commit side drives requests and observes the offered BID.
  modport master (
    output br_req, en_alloc, snoop_hit, bco_valid, bc_valid, bc_bid,
    input  bp_valid, bp_bid, readyn, inflight_cnt, err_order, err_underflow
  );

  // Allocator side.
  modport slave (
    input  br_req, en_alloc, snoop_hit, bco_valid, bc_valid, bc_bid,
    output bp_valid, bp_bid, readyn, inflight_cnt, err_order, err_underflow
  );
endinterface

// File: rtl/decode_alloc_bid.sv
// Branch-ID allocator: hands out program-ordered BIDs to decoded branches,
// frees them on in-order commit, drops all on flush, stalls when full.
module decode_alloc_bid #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BID_W = 4
) (
  input logic               clk,
  input logic               resetn,
  decode_alloc_bid_if.slave bus
);

  localparam logic [2:0] DepthCnt = 3'(DEPTH);

  logic [BID_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [BID_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             err_order_q, err_order_d;
  logic             err_underflow_q, err_underflow_d;

  logic full, flush, do_alloc, do_commit;

  // Decode of this cycle's events and offered outputs.
  always_comb begin
    full      = (count_q == DepthCnt);
    flush     = bus.snoop_hit | bus.bco_valid;
    do_alloc  = bus.br_req & bus.en_alloc & ~full & ~flush;
    do_commit = bus.bc_valid & ~flush & (count_q != 3'd0) & (bus.bc_bid == commit_ptr_q);

    bus.bp_bid        = alloc_ptr_q;
    bus.bp_valid      = bus.br_req & ~full;
    bus.readyn        = bus.br_req & full;
    bus.inflight_cnt  = count_q;
    bus.err_order     = err_order_q;
    bus.err_underflow = err_underflow_q;
  end

  // Next-state: flush overrides alloc/commit; errors are checked every cycle.
  always_comb begin
    alloc_ptr_d     = alloc_ptr_q;
    commit_ptr_d    = commit_ptr_q;
    count_d         = count_q;
    err_order_d     = err_order_q;
    err_underflow_d = err_underflow_q;

    if (bus.bc_valid && (count_q != 3'd0) && (bus.bc_bid != commit_ptr_q)) begin
      err_order_d = 1'b1;
    end
    if (bus.bc_valid && (count_q == 3'd0)) begin
      err_underflow_d = 1'b1;
    end

    if (flush) begin
      // Restart commit tracking at the next fresh BID so new IDs never alias
      // ones still draining from before the flush.
      count_d      = 3'd0;
      commit_ptr_d = alloc_ptr_q;
    end else begin
      if (do_alloc) begin
        alloc_ptr_d = alloc_ptr_q + 1'b1;
      end
      if (do_commit) begin
        commit_ptr_d = commit_ptr_q + 1'b1;
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alloc_ptr_q     <= '0;
      commit_ptr_q    <= '0;
      count_q         <= 3'd0;
      err_order_q     <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      alloc_ptr_q     <= alloc_ptr_d;
      commit_ptr_q    <= commit_ptr_d;
      count_q         <= count_d;
      err_order_q     <= err_order_d;
      err_underflow_q <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_decode_alloc_bid.sv
// Directed bench for decode_alloc_bid: expected BIDs are queued as stimulus is
// issued and a negedge monitor checks every consumed BID against the queue.
module tb_decode_alloc_bid;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_bad;
  int   exp_q[$];

  decode_alloc_bid_if #(.BID_W(4)) bus ();

  decode_alloc_bid #(.DEPTH(4), .BID_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every BID actually consumed by decode must match the queue head.
  always @(negedge clk) begin
    if (resetn && bus.bp_valid && bus.en_alloc && !bus.snoop_hit && !bus.bco_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bid_unexpected: got %0d, expected no allocation", bus.bp_bid);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.bp_bid) != e) begin
          n_bad++;
          $display("FAIL bid: got %0d, expected %0d", bus.bp_bid, e);
        end
      end
    end
  end

  // One cycle: drive inputs, optionally queue the expected BID, check count and
  // readyn against the pre-edge state, then advance past the clock edge.
  task automatic step(input logic br, input logic en, input logic snp, input logic bco,
                      input logic bcv, input int bid, input int exp_bid, input int exp_cnt,
                      input int exp_rdy);
    bus.br_req    = br;
    bus.en_alloc  = en;
    bus.snoop_hit = snp;
    bus.bco_valid = bco;
    bus.bc_valid  = bcv;
    bus.bc_bid    = 4'(bid);
    if (exp_bid >= 0) exp_q.push_back(exp_bid);
    @(negedge clk);
    check("inflight_cnt", int'(bus.inflight_cnt), exp_cnt);
    check("readyn", int'(bus.readyn), exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, int'(bus.inflight_cnt), 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    resetn        = 1'b0;
    bus.br_req    = 1'b0;
    bus.en_alloc  = 1'b0;
    bus.snoop_hit = 1'b0;
    bus.bco_valid = 1'b0;
    bus.bc_valid  = 1'b0;
    bus.bc_bid    = 4'd0;
    #3;
    check("rst_cnt", int'(bus.inflight_cnt), 0);
    check("rst_bid", int'(bus.bp_bid), 0);
    check("rst_valid", int'(bus.bp_valid), 0);
    check("rst_readyn", int'(bus.readyn), 0);
    check("rst_err_order", int'(bus.err_order), 0);
    check("rst_err_underflow", int'(bus.err_underflow), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Fill to DEPTH, then stall.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, i, i, 0);
    step(1, 1, 0, 0, 0, 0, -1, 4, 1);
    check("full_hold_bid", int'(bus.bp_bid), 4);
    check("full_valid", int'(bus.bp_valid), 0);

    // Commit while full: slot freed is not reused in the same cycle.
    step(1, 1, 0, 0, 1, 0, -1, 4, 1);
    step(1, 1, 0, 0, 0, 0, 4, 3, 0);
    // Drain BIDs 1..4.
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, i, -1, 5 - i, 0);

    // Alternate alloc/commit across the 15 -> 0 wrap.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0, 0, (5 + i) % 16, 0, 0);
      step(0, 0, 0, 0, 1, (5 + i) % 16, -1, 1, 0);
    end
    // Simultaneous alloc and commit keep the count.
    step(1, 1, 0, 0, 0, 0, 9, 0, 0);
    step(1, 1, 0, 0, 1, 9, 10, 1, 0);
    step(0, 0, 0, 0, 1, 10, -1, 1, 0);
    check("wrap_cnt", int'(bus.inflight_cnt), 0);
    check("wrap_err_order", int'(bus.err_order), 0);
    check("wrap_err_underflow", int'(bus.err_underflow), 0);

    // BCO with coincident commit: BIDs 11,12,13 dropped, next BID is 14.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 11 + i, i, 0);
    step(0, 0, 0, 1, 1, 11, -1, 3, 0);
    check("bco_cnt", int'(bus.inflight_cnt), 0);
    step(1, 1, 0, 0, 0, 0, 14, 0, 0);
    check("bco_err_order", int'(bus.err_order), 0);
    check("bco_err_underflow", int'(bus.err_underflow), 0);

    // Out-of-order commit: count 2 (BIDs 14,15), commit_ptr 14, commit 15.
    step(1, 1, 0, 0, 0, 0, 15, 1, 0);
    step(0, 0, 0, 0, 1, 15, -1, 2, 0);
    check("err_order_set", int'(bus.err_order), 1);
    check("err_order_cnt", int'(bus.inflight_cnt), 2);
    // Snoop flush with a branch present: nothing allocated.
    step(1, 1, 1, 0, 0, 0, -1, 2, 0);
    check("snoop_cnt", int'(bus.inflight_cnt), 0);
    check("snoop_bid", int'(bus.bp_bid), 0);
    // Commit with nothing in flight.
    step(0, 0, 0, 0, 1, 0, -1, 0, 0);
    check("err_underflow_set", int'(bus.err_underflow), 1);
    check("err_order_sticky", int'(bus.err_order), 1);
    // Offered but not consumed.
    step(1, 0, 0, 0, 0, 0, -1, 0, 0);
    check("noen_bid", int'(bus.bp_bid), 0);
    idle();
    check("err_underflow_sticky", int'(bus.err_underflow), 1);

    // Asynchronous reset mid-burst at count 3.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, i, i, 0);
    bus.br_req   = 1'b1;
    bus.en_alloc = 1'b1;
    #1;
    resetn     = 1'b0;
    bus.br_req = 1'b0;
    #1;
    check("arst_cnt", int'(bus.inflight_cnt), 0);
    check("arst_bid", int'(bus.bp_bid), 0);
    check("arst_readyn", int'(bus.readyn), 0);
    check("arst_err_order", int'(bus.err_order), 0);
    check("arst_err_underflow", int'(bus.err_underflow), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_cnt", int'(bus.inflight_cnt), 1);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
